// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit scheduler.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_DATA     = 3'd2,
    ST_EOP      = 3'd3,
    ST_WAIT_EOP = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_HS   = 2'b01;
  localparam logic [1:0] GRANT_DP   = 2'b10;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'b0111_1111;

endpackage

// File: rtl/tx_sched_arb.sv
// Packet-level arbiter: hs has priority, but after MAX_HS_STREAK back-to-back
// hs grants a waiting dp requester is served once.
module tx_sched_arb
  import tx_sched_pkg::*;
#(
  parameter int MAX_HS_STREAK = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic       dp_req,
  input  logic       arb_en,
  output logic [1:0] winner
);

  localparam int SW = $clog2(MAX_HS_STREAK + 1);

  logic [SW-1:0] hs_streak_r;
  logic          at_limit_s;

  assign at_limit_s = (hs_streak_r == SW'(MAX_HS_STREAK));

  // Priority decision; only meaningful while the scheduler is idle.
  always_comb begin
    winner = GRANT_NONE;
    if (!arb_en) begin
      winner = GRANT_NONE;
    end else if (hs_req && !(dp_req && at_limit_s)) begin
      winner = GRANT_HS;
    end else if (dp_req) begin
      winner = GRANT_DP;
    end else begin
      winner = GRANT_NONE;
    end
  end

  // Saturating count of consecutive hs grants; any dp grant clears it.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      hs_streak_r <= {SW{1'b0}};
    end else if (winner == GRANT_HS) begin
      if (!at_limit_s) begin
        hs_streak_r <= hs_streak_r + SW'(1);
      end else begin
        hs_streak_r <= hs_streak_r;
      end
    end else if (winner == GRANT_DP) begin
      hs_streak_r <= {SW{1'b0}};
    end else begin
      hs_streak_r <= hs_streak_r;
    end
  end

endmodule

// File: rtl/tx_sched.sv
// Transmit scheduler: shares one byte serializer between the handshake (hs)
// and data-packet (dp) requesters. Emits SYNC, forwards the granted stream,
// triggers EOP and enforces the inter-packet gap.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int         IPG_CYCLES    = 16,
  parameter int         MAX_HS_STREAK = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic [7:0] hs_byte,
  input  logic       hs_last,
  output logic       hs_pop,
  input  logic       dp_req,
  input  logic [7:0] dp_byte,
  input  logic       dp_last,
  output logic       dp_pop,
  input  logic       ser_ready,
  output logic       ser_load,
  output logic [7:0] ser_byte,
  output logic       eop_start,
  input  logic       eop_done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       underrun
);

  localparam int GW = $clog2(IPG_CYCLES + 1);

  state_t        state_r, state_nxt_s;
  logic [GW-1:0] gap_r, gap_nxt_s;
  logic [1:0]    grant_r, grant_nxt_s;
  logic [1:0]    winner_s;
  logic          g_req_s, g_last_s;
  logic [7:0]    g_byte_s;

  tx_sched_arb #(
    .MAX_HS_STREAK(MAX_HS_STREAK)
  ) u_arb (
    .clk    (clk),
    .n_rst  (n_rst),
    .hs_req (hs_req),
    .dp_req (dp_req),
    .arb_en (state_r == ST_IDLE),
    .winner (winner_s)
  );

  // Select the granted requester's stream; the other one is ignored entirely.
  always_comb begin
    g_req_s  = 1'b0;
    g_byte_s = 8'h00;
    g_last_s = 1'b0;
    case (grant_r)
      GRANT_HS: begin
        g_req_s  = hs_req;
        g_byte_s = hs_byte;
        g_last_s = hs_last;
      end
      GRANT_DP: begin
        g_req_s  = dp_req;
        g_byte_s = dp_byte;
        g_last_s = dp_last;
      end
      default: begin
        g_req_s  = 1'b0;
        g_byte_s = 8'h00;
        g_last_s = 1'b0;
      end
    endcase
  end

  // Packet sequencing: next state, gap counter, grant and Mealy outputs.
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_r;
    grant_nxt_s = grant_r;
    ser_load    = 1'b0;
    ser_byte    = 8'h00;
    hs_pop      = 1'b0;
    dp_pop      = 1'b0;
    eop_start   = 1'b0;
    underrun    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (winner_s != GRANT_NONE) begin
          grant_nxt_s = winner_s;
          state_nxt_s = ST_SYNC;
        end else begin
          grant_nxt_s = GRANT_NONE;
        end
      end
      ST_SYNC: begin
        if (ser_ready) begin
          ser_load    = 1'b1;
          ser_byte    = SYNC_BYTE;
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_DATA: begin
        if (ser_ready && g_req_s) begin
          ser_load = 1'b1;
          ser_byte = g_byte_s;
          hs_pop   = (grant_r == GRANT_HS);
          dp_pop   = (grant_r == GRANT_DP);
          if (g_last_s) begin
            state_nxt_s = ST_EOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else if (ser_ready) begin
          // Requester vanished mid-packet: close the packet anyway.
          underrun    = 1'b1;
          state_nxt_s = ST_EOP;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_EOP: begin
        if (ser_ready) begin
          eop_start   = 1'b1;
          state_nxt_s = ST_WAIT_EOP;
        end else begin
          state_nxt_s = ST_EOP;
        end
      end
      ST_WAIT_EOP: begin
        if (eop_done) begin
          gap_nxt_s   = GW'(IPG_CYCLES - 1);
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_WAIT_EOP;
        end
      end
      ST_GAP: begin
        if (gap_r == {GW{1'b0}}) begin
          grant_nxt_s = GRANT_NONE;
          state_nxt_s = ST_IDLE;
        end else begin
          gap_nxt_s = gap_r - GW'(1);
        end
      end
      default: begin
        grant_nxt_s = GRANT_NONE;
        gap_nxt_s   = {GW{1'b0}};
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, gap counter and grant registers; reset abandons any packet.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_r <= ST_IDLE;
      gap_r   <= {GW{1'b0}};
      grant_r <= GRANT_NONE;
    end else begin
      state_r <= state_nxt_s;
      gap_r   <= gap_nxt_s;
      grant_r <= grant_nxt_s;
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_tx_sched.sv
// Directed, scoreboard-based bench for tx_sched.
module tb_tx_sched;

  logic       clk;
  logic       n_rst;
  logic       hs_req, hs_last, hs_pop;
  logic [7:0] hs_byte;
  logic       dp_req, dp_last, dp_pop;
  logic [7:0] dp_byte;
  logic       ser_ready, ser_load, eop_start, eop_done, busy, underrun;
  logic [7:0] ser_byte;
  logic [1:0] grant;

  logic [8:0] hs_q[$];
  logic [8:0] dp_q[$];
  logic [9:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_load_cyc = 0;
  int sync_cyc = 0;
  int eop_cyc = 0;
  int urun_cyc = 0;
  int eop_cnt = 0;
  int urun_cnt = 0;
  bit hs_take = 1'b0;
  bit dp_take = 1'b0;
  bit thr = 1'b0;

  tx_sched dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .hs_req    (hs_req),
    .hs_byte   (hs_byte),
    .hs_last   (hs_last),
    .hs_pop    (hs_pop),
    .dp_req    (dp_req),
    .dp_byte   (dp_byte),
    .dp_last   (dp_last),
    .dp_pop    (dp_pop),
    .ser_ready (ser_ready),
    .ser_load  (ser_load),
    .ser_byte  (ser_byte),
    .eop_start (eop_start),
    .eop_done  (eop_done),
    .grant     (grant),
    .busy      (busy),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    hs_req  = (hs_q.size() > 0);
    hs_byte = hs_req ? hs_q[0][7:0] : 8'h00;
    hs_last = hs_req ? hs_q[0][8] : 1'b0;
    dp_req  = (dp_q.size() > 0);
    dp_byte = dp_req ? dp_q[0][7:0] : 8'h00;
    dp_last = dp_req ? dp_q[0][8] : 1'b0;
  endtask

  task automatic push_hs(input logic [7:0] b, input logic last);
    hs_q.push_back({last, b});
    refresh();
  endtask

  task automatic push_dp(input logic [7:0] b, input logic last);
    dp_q.push_back({last, b});
    refresh();
  endtask

  // pops = {hs_pop, dp_pop} expected together with the loaded byte
  task automatic exp_load(input logic [1:0] pops, input logic [7:0] b);
    exp_q.push_back({pops, b});
  endtask

  // Requester and serializer-ready models, updated just after each clock edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (hs_take && hs_q.size() > 0) void'(hs_q.pop_front());
    if (dp_take && dp_q.size() > 0) void'(dp_q.pop_front());
    hs_take = 1'b0;
    dp_take = 1'b0;
    ser_ready = thr ? ((cyc % 64) == 0) : 1'b1;
    refresh();
  end

  // Output monitor / scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (ser_load) begin
      last_load_cyc = cyc;
      if ({hs_pop, dp_pop} == 2'b00) sync_cyc = cyc;
      chk("load_when_ready", 32'(ser_ready), 32'd1);
      if (exp_q.size() == 0) begin
        chk("load_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("load", 32'({hs_pop, dp_pop, ser_byte}), 32'(exp_q.pop_front()));
      end
    end else begin
      chk("quiet_out", 32'({hs_pop, dp_pop, ser_byte}), 32'd0);
    end
    if (eop_start) begin
      eop_cnt++;
      eop_cyc = cyc;
    end
    if (underrun) begin
      urun_cnt++;
      urun_cyc = cyc;
    end
    hs_take = hs_pop;
    dp_take = dp_pop;
  end

  task automatic wait_grant(input string tag, input logic [1:0] g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant === 2'b00 && n < 200);
    chk(tag, 32'(grant), 32'(g));
  endtask

  task automatic finish_pkt(input string tag);
    int n;
    int gap;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (eop_start !== 1'b1 && n < 2000);
    chk({tag, "_eop"}, 32'(eop_start), 32'd1);
    @(posedge clk);
    #1 eop_done = 1'b1;
    @(posedge clk);
    #1 eop_done = 1'b0;
    gap = 0;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      gap++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_gap"}, 32'(gap), 32'd16);
    chk({tag, "_grant_idle"}, 32'(grant), 32'd0);
  endtask

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  logic [1:0] g3 [7];
  int n6;

  initial begin
    n_rst = 1'b1;
    ser_ready = 1'b1;
    eop_done = 1'b0;
    refresh();

    // reset state
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({ser_load, eop_start, underrun, hs_pop, dp_pop}), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b0;

    // single dp packet
    @(posedge clk);
    #2;
    exp_load(2'b00, 8'h7F);
    exp_load(2'b01, 8'hA1);
    exp_load(2'b01, 8'hB2);
    exp_load(2'b01, 8'hC3);
    push_dp(8'hA1, 1'b0);
    push_dp(8'hB2, 1'b0);
    push_dp(8'hC3, 1'b1);
    wait_grant("t1_grant", 2'b10);
    finish_pkt("t1");
    chk("t1_back_to_back", 32'(last_load_cyc - sync_cyc), 32'd3);
    chk("t1_eop_delay", 32'(eop_cyc - last_load_cyc), 32'd1);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // simultaneous requests: hs first, dp after the gap
    @(posedge clk);
    #2;
    exp_load(2'b00, 8'h7F);
    exp_load(2'b10, 8'hD2);
    exp_load(2'b00, 8'h7F);
    exp_load(2'b01, 8'h5A);
    exp_load(2'b01, 8'h6B);
    push_hs(8'hD2, 1'b1);
    push_dp(8'h5A, 1'b0);
    push_dp(8'h6B, 1'b1);
    wait_grant("t2_grant_hs", 2'b01);
    finish_pkt("t2_hs");
    wait_grant("t2_grant_dp", 2'b10);
    finish_pkt("t2_dp");
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // starvation limit: four hs, then dp, then hs wins the next tie
    g3[0] = 2'b01; g3[1] = 2'b01; g3[2] = 2'b01; g3[3] = 2'b01;
    g3[4] = 2'b10; g3[5] = 2'b01; g3[6] = 2'b10;
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      exp_load(2'b00, 8'h7F);
      exp_load(2'b10, 8'hD2);
    end
    exp_load(2'b00, 8'h7F);
    exp_load(2'b01, 8'h77);
    exp_load(2'b00, 8'h7F);
    exp_load(2'b10, 8'hD2);
    exp_load(2'b00, 8'h7F);
    exp_load(2'b01, 8'h88);
    for (int i = 0; i < 5; i++) push_hs(8'hD2, 1'b1);
    push_dp(8'h77, 1'b1);
    push_dp(8'h88, 1'b1);
    for (int i = 0; i < 7; i++) begin
      wait_grant($sformatf("t3_grant%0d", i), g3[i]);
      finish_pkt($sformatf("t3_pkt%0d", i));
    end
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // underrun after two bytes
    @(posedge clk);
    #2;
    exp_load(2'b00, 8'h7F);
    exp_load(2'b01, 8'h11);
    exp_load(2'b01, 8'h22);
    push_dp(8'h11, 1'b0);
    push_dp(8'h22, 1'b0);
    wait_grant("t4_grant", 2'b10);
    finish_pkt("t4");
    chk("t4_underrun_cnt", 32'(urun_cnt), 32'd1);
    chk("t4_underrun_delay", 32'(urun_cyc - last_load_cyc), 32'd1);
    chk("t4_eop_delay", 32'(eop_cyc - urun_cyc), 32'd1);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // throttled serializer: one ready every 64 cycles
    @(posedge clk);
    #2;
    thr = 1'b1;
    exp_load(2'b00, 8'h7F);
    for (int i = 1; i <= 5; i++) begin
      exp_load(2'b01, 8'(i));
      push_dp(8'(i), (i == 5));
    end
    wait_grant("t5_grant", 2'b10);
    finish_pkt("t5");
    thr = 1'b0;
    chk("t5_spacing", 32'(last_load_cyc - sync_cyc), 32'd320);
    chk("t5_eop_delay", 32'(eop_cyc - last_load_cyc), 32'd64);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset in the middle of DATA
    @(posedge clk);
    #2;
    exp_load(2'b00, 8'h7F);
    for (int i = 0; i < 4; i++) begin
      exp_load(2'b01, 8'h31 + 8'(i));
      push_dp(8'h31 + 8'(i), (i == 3));
    end
    n6 = 0;
    do begin
      @(negedge clk);
      n6++;
    end while (dp_pop !== 1'b1 && n6 < 100);
    chk("t6_in_data", 32'(dp_pop), 32'd1);
    #2 n_rst = 1'b1;
    #1;
    chk("t6_rst_outs", 32'({ser_load, dp_pop, hs_pop, eop_start, underrun}), 32'd0);
    chk("t6_rst_byte", 32'(ser_byte), 32'd0);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    dp_q.delete();
    exp_q.delete();
    refresh();
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #2;
    exp_load(2'b00, 8'h7F);
    exp_load(2'b01, 8'h41);
    push_dp(8'h41, 1'b1);
    wait_grant("t6_grant", 2'b10);
    finish_pkt("t6");
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    chk("eop_total", 32'(eop_cnt), 32'd13);
    chk("underrun_total", 32'(urun_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
